rotl_seq_unshifter: RTL
=======================

// Module: rotl_seq_unshifter
// PURPOSE
//  Sequential inverse of the combinational rotate-right shifter: rotates a WIDTH-bit word LEFT by amt,
//  one bit position per clock. Restores operands that were rotated right on the DA/LMS datapath
//  (e.g. re-aligning a partial-product/LUT address word before weight update).
//  Valid/ready on both sides; single operation in flight.
// PARAMETERS
//  WIDTH  8                 data width; must be a power of two (>=2)
//  AMT_W  $clog2(WIDTH)=3   rotate-amount width; every amt value 0..WIDTH-1 is legal
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_data/in_amt valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  in_data    in   WIDTH  word to un-rotate
//  in_amt     in   AMT_W  left-rotate amount
//  out_valid  out  1      out_data holds result
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  in_data rotated left by in_amt
//  busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, data_q=0, cnt_q=0, out_valid=0, busy=0, in_ready=1 once rst_n=1.
//  States: IDLE, SHIFT, DONE (2-bit encoding).
//  IDLE: in_ready=1. Accept edge = in_valid && in_ready. On it: data_q<=in_data, cnt_q<=in_amt;
//    in_amt==0 -> DONE, else -> SHIFT. in_valid low -> stay IDLE; inputs ignored.
//  SHIFT: each edge data_q<={data_q[WIDTH-2:0],data_q[WIDTH-1]}, cnt_q<=cnt_q-1;
//    edge where cnt_q==1 -> DONE (last rotation applied on that edge). Inputs ignored; in_ready=0.
//  DONE: out_valid=1, out_data=data_q, stable while out_ready=0 (no bound on stall).
//    out_valid && out_ready edge -> IDLE; out_valid falls next cycle. No same-edge accept of new input.
//  Latency: out_valid first high after exactly in_amt edges following the accept edge (0 => cycle
//    right after accept). Throughput: one op per in_amt+2 cycles with out_ready=1.
//  out_data outside DONE = data_q (don't care to consumer; not forced to 0).
//  Width rule: pure rotation, no sign/zero fill; bit count preserved; cnt_q is AMT_W bits, never wraps
//    below 0 (leaves SHIFT at 1).
//  Reset mid-SHIFT or mid-DONE: operation discarded, outputs return to reset values immediately.
//  Contract: rotl_seq_unshifter(rotr(x,a),a)==x for all x, a.
// STRUCTURE
//  Shared package dalms_pkg: state localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; DATA_W=8.
//  One sub-module: rotl1_step (combinational WIDTH-bit rotate-left-by-one), reused by the DA datapath.
//  Remainder: one FSM always block + data/count registers in this file.
// TESTING
//  1 in_data=8'h96, in_amt=3, out_ready=1 -> out_valid 3 edges after accept, out_data=8'hB4, then IDLE.
//  2 in_data=8'h5A, in_amt=0 -> out_valid cycle after accept, out_data=8'h5A; in_ready=0 until popped.
//  3 in_data=8'h01, in_amt=7 -> out_data=8'h80 after 7 edges; in_valid pulses during SHIFT ignored.
//  4 amt=2, data=8'hC3, out_ready=0 for 5 cycles in DONE -> out_data=8'h0F held, busy=1, in_ready=0.
//  5 rst_n low mid-SHIFT (amt=5, 2 rotations done) -> out_valid=0, busy=0 at once; next op 8'h80,amt=1 -> 8'h01.
//  6 All 256x8 (x,a): feed rotr model output -> out_data==x; random out_ready backpressure; no lost or duplicate results.

Source files
------------

// File: rtl/dalms_pkg.sv
// Shared DA/LMS datapath definitions: FSM state encoding and default data width.
package dalms_pkg;

    localparam int         DATA_W   = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/rotl_seq_unshifter_if.sv
// Request/result handshake bundle for the sequential rotate-left unit.
interface rotl_seq_unshifter_if
    import dalms_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int AMT_W = $clog2(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/rotl_seq_unshifter_rotl1_step.sv
// Combinational rotate-left by one bit position; no fill, bit count preserved.
module rotl1_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = {din[WIDTH-2:0], din[WIDTH-1]};

endmodule

// File: rtl/rotl_seq_unshifter.sv
// Purpose: rotate a word left by amt, one bit per clock (undoes a rotate-right).
// Latency: out_valid rises in_amt edges after the accept edge (amt 0 -> next cycle).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one op in flight.
module rotl_seq_unshifter
    import dalms_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rotl_seq_unshifter_if.slave  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_rot;
    logic [AMT_W-1:0] cnt_q;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic             accept;

    rotl1_step #(.WIDTH(WIDTH)) u_step (
        .din  (data_q),
        .dout (data_rot)
    );

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = (bus.in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // the edge that consumes the last count also applies the last rotation
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= bus.in_data;
            cnt_q  <= bus.in_amt;
        end else if (state_q == SHIFT) begin
            data_q <= data_rot;
            cnt_q  <= cnt_q - AMT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy;

endmodule
